// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared definitions for the multi-channel LED pattern generator.
//   - channel mode encodings (OFF / BLINK / PWM / BREATHE) and their width
//   - PWM duty width and the "always on" duty value
//   - pwm_level(): compare helper shared by the PWM and BREATHE modes
package led_pattern_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_PWM     = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd3;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

  // phase < duty gives duty/256 on-time; full-scale duty is forced to a
  // constant 1 so that 8'hFF really means "always on" rather than 255/256.
  function automatic logic pwm_level(input logic [DUTY_W-1:0] phase,
                                     input logic [DUTY_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (phase < duty);
  endfunction

endpackage

// File: rtl/led_channel.sv
// led_channel: one independently configured LED output.
//   CLK, RST   clock, synchronous active-high reset
//   i_tick     one-cycle timebase pulse shared by all channels
//   i_phase    shared free-running 8-bit PWM phase
//   i_we       config write strobe already decoded for this channel
//   i_mode     OFF / BLINK / PWM / BREATHE
//   i_period   ticks per blink half-period or per breathe step (0 stored as 1)
//   i_duty     PWM duty in 1/256 units
//   o_led      registered LED output
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_tick,
  input  logic [DUTY_W-1:0] i_phase,
  input  logic              i_we,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_led
);

  logic [MODE_W-1:0] r_mode;
  logic [CNT_W-1:0]  r_period;
  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_state;    // blink level
  logic [DUTY_W-1:0] r_bduty;    // breathe internal duty
  logic              r_dir_up;   // breathe direction
  logic              r_led;

  logic [CNT_W-1:0]  w_period_in;
  logic              w_wrap;
  logic              w_adv;
  logic              w_led_next;

  assign w_period_in = (i_period == '0) ? CNT_W'(1) : i_period;
  assign w_wrap      = (r_cnt == r_period - CNT_W'(1));
  // Only the time-based modes consume ticks; OFF and PWM hold the counters.
  assign w_adv       = i_tick && ((r_mode == MODE_BLINK) || (r_mode == MODE_BREATHE));

  // A write has priority over a coincident tick: the tick is simply lost
  // for this channel, so counting restarts cleanly from the write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode   <= MODE_OFF;
      r_period <= CNT_W'(1);
      r_duty   <= '0;
      r_cnt    <= '0;
      r_state  <= 1'b0;
      r_bduty  <= '0;
      r_dir_up <= 1'b1;
    end else if (i_we) begin
      r_mode   <= i_mode;
      r_period <= w_period_in;
      r_duty   <= i_duty;
      r_cnt    <= '0;
      r_state  <= 1'b0;
      r_bduty  <= '0;
      r_dir_up <= 1'b1;
    end else if (w_adv) begin
      if (w_wrap) begin
        r_cnt <= '0;
        if (r_mode == MODE_BLINK) begin
          r_state <= ~r_state;
        end else begin
          // Triangle 0..255..0 with each endpoint visited once: the flip
          // happens on the step that lands on the endpoint.
          if (r_dir_up) begin
            r_bduty <= r_bduty + 8'd1;
            if (r_bduty == DUTY_FULL - 8'd1) r_dir_up <= 1'b0;
          end else begin
            r_bduty <= r_bduty - 8'd1;
            if (r_bduty == 8'd1) r_dir_up <= 1'b1;
          end
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_led_next = 1'b0;
    case (r_mode)
      MODE_BLINK:   w_led_next = r_state;
      MODE_PWM:     w_led_next = pwm_level(i_phase, r_duty);
      MODE_BREATHE: w_led_next = pwm_level(i_phase, r_bduty);
      default:      w_led_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_led <= 1'b0;
    else     r_led <= w_led_next;
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_LED-channel LED driver with OFF/BLINK/PWM/BREATHE modes.
//   CLK, RST    clock, synchronous active-high reset
//   cfg_we      single-cycle config write strobe
//   cfg_idx     target channel; indices >= NUM_LED are ignored
//   cfg_mode    0=OFF 1=BLINK 2=PWM 3=BREATHE
//   cfg_period  ticks per blink half-period / breathe step
//   cfg_duty    PWM duty in 1/256 units
//   LED         registered LED outputs
//   tick_o      one-cycle timebase pulse every CLK_HZ/TICK_HZ cycles
// The prescaler and the PWM phase counter are shared by all channels.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LED = 4,
  parameter int CLK_HZ  = 125000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [MODE_W-1:0]  cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [DUTY_W-1:0]  cfg_duty,
  output logic [NUM_LED-1:0] LED,
  output logic               tick_o
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = $clog2(TICK_DIV);

  logic [PRESC_W-1:0] r_presc;
  logic [DUTY_W-1:0]  r_phase;
  logic               w_tick;
  logic               w_idx_ok;
  logic [NUM_LED-1:0] w_we;

  // Tick is decoded from the count, so it is high exactly while the count
  // sits at TICK_DIV-1; the first pulse is TICK_DIV cycles after reset.
  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));
  assign tick_o = w_tick;

  always_ff @(posedge CLK) begin
    if (RST)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) r_phase <= '0;
    else     r_phase <= r_phase + 8'd1;
  end

  // Needed when NUM_LED is not a power of two: out-of-range indices must not
  // alias onto a real channel.
  assign w_idx_ok = (int'(cfg_idx) < NUM_LED);

  always_comb begin
    w_we = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      if (cfg_we && w_idx_ok && (cfg_idx == IDX_W'(i))) w_we[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    led_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .CLK      (CLK),
      .RST      (RST),
      .i_tick   (w_tick),
      .i_phase  (r_phase),
      .i_we     (w_we[g]),
      .i_mode   (cfg_mode),
      .i_period (cfg_period),
      .i_duty   (cfg_duty),
      .o_led    (LED[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed, table-driven bench for led_pattern_gen.
// Two instances share the config bus: a 4-channel one (main checks) and a
// 3-channel one, on which index 3 is a genuinely out-of-range channel.
// Timebase: CLK_HZ=100, TICK_HZ=10, so one tick every 10 cycles.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [7:0]  cfg_duty = '0;
  logic [3:0]  led;
  logic        tick;
  logic [2:0]  led3;
  logic        tick3;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  led_pattern_gen #(
    .NUM_LED (4), .CLK_HZ (100), .TICK_HZ (10), .CNT_W (16)
  ) dut (
    .CLK (CLK), .RST (RST), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
    .cfg_mode (cfg_mode), .cfg_period (cfg_period), .cfg_duty (cfg_duty),
    .LED (led), .tick_o (tick)
  );

  led_pattern_gen #(
    .NUM_LED (3), .CLK_HZ (100), .TICK_HZ (10), .CNT_W (16)
  ) dut3 (
    .CLK (CLK), .RST (RST), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
    .cfg_mode (cfg_mode), .cfg_period (cfg_period), .cfg_duty (cfg_duty),
    .LED (led3), .tick_o (tick3)
  );

  // ---------------- vector tables ----------------
  typedef struct {
    logic [15:0] period;
    int          exp_rise;   // cycles from write edge until LED[0] first high
    int          exp_high;   // length of the first high phase
  } blink_vec_t;

  typedef struct {
    logic [7:0] duty;
    int         exp_high;    // high cycles in any 256-cycle window
  } pwm_vec_t;

  blink_vec_t bv[4];
  pwm_vec_t   pv[6];

  // ---------------- checker / drivers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge and
  // the task returns at the negedge right after that edge.
  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] mode,
                           input logic [15:0] period, input logic [7:0] duty);
    cfg_we     = 1'b1;
    cfg_idx    = idx;
    cfg_mode   = mode;
    cfg_period = period;
    cfg_duty   = duty;
    @(negedge CLK);
    cfg_we     = 1'b0;
  endtask

  // Leaves the bench at a negedge where tick_o is high, so a write issued
  // next lands on the same edge as a tick.
  task automatic sync_tick(input string name);
    int guard;
    guard = 0;
    while (!tick && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk(name, int'(tick), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int rise, fall, others_bad, cnt, err_a, err_b, err_c, peak_bad, trough_bad;
    int win[20];

    bv[0] = '{16'd0, 11, 10};   // period 0 behaves as period 1
    bv[1] = '{16'd1, 11, 10};
    bv[2] = '{16'd3, 31, 30};   // first toggle 3 ticks after the write
    bv[3] = '{16'd5, 51, 50};

    pv[0] = '{8'd64,  64};
    pv[1] = '{8'd0,   0};
    pv[2] = '{8'd255, 256};
    pv[3] = '{8'd1,   1};
    pv[4] = '{8'd128, 128};
    pv[5] = '{8'd254, 254};

    // --- reset and idle ---
    repeat (3) @(negedge CLK);
    chk("reset_led", int'(led), 0);
    chk("reset_tick", int'(tick), 0);
    RST = 1'b0;
    err_a = 0; err_b = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (led != 4'b0000 || led3 != 3'b000) err_a++;
      if (tick != ((n % 10) == 9) || tick3 != ((n % 10) == 9)) err_b++;
    end
    chk("idle_led_errors", err_a, 0);
    chk("idle_tick_errors", err_b, 0);

    // --- BLINK on ch0, write coincident with tick ---
    for (int r = 0; r < 4; r++) begin
      sync_tick($sformatf("blink%0d_sync", r));
      cfg_write(2'd0, MODE_BLINK, bv[r].period, 8'd0);
      rise = -1; fall = -1; others_bad = 0;
      for (int n = 1; n <= 2 * bv[r].exp_rise + 20 && fall < 0; n++) begin
        @(negedge CLK);
        if (led[3:1] != 3'b000) others_bad++;
        if (rise < 0 && led[0]) rise = n;
        else if (rise >= 0 && !led[0]) fall = n;
      end
      chk($sformatf("blink%0d_rise", r), rise, bv[r].exp_rise);
      chk($sformatf("blink%0d_high", r), (fall < 0) ? -1 : fall - rise, bv[r].exp_high);
      chk($sformatf("blink%0d_others", r), others_bad, 0);
    end

    // --- PWM on ch1 ---
    for (int r = 0; r < 6; r++) begin
      cfg_write(2'd1, MODE_PWM, 16'd1, pv[r].duty);
      repeat (2) @(negedge CLK);
      cnt = 0;
      for (int n = 0; n < 256; n++) begin
        @(negedge CLK);
        cnt += int'(led[1]);
      end
      chk($sformatf("pwm%0d_high", r), cnt, pv[r].exp_high);
    end

    // --- BREATHE on ch2, period 1: duty k after tick k, peak at 255, 0 at 510 ---
    sync_tick("breathe_sync");
    cfg_write(2'd2, MODE_BREATHE, 16'd1, 8'd0);
    for (int i = 0; i < 20; i++) win[i] = 0;
    peak_bad = 0; trough_bad = 0;
    for (int n = 1; n <= 5120; n++) begin
      @(negedge CLK);
      win[(n - 1) / 256] += int'(led[2]);
      if (n >= 2551 && n <= 2560 && !led[2]) peak_bad++;
      if (n >= 5101 && n <= 5110 && led[2]) trough_bad++;
    end
    err_a = 0; err_b = 0;
    for (int i = 1; i <= 8; i++) if (win[i] < win[i-1]) err_a++;
    for (int i = 11; i <= 19; i++) if (win[i] > win[i-1]) err_b++;
    chk("breathe_rising_windows", err_a, 0);
    chk("breathe_falling_windows", err_b, 0);
    chk("breathe_ramp_grows", int'(win[8] > win[0] + 100), 1);
    chk("breathe_peak_full_on", peak_bad, 0);
    chk("breathe_trough_off", trough_bad, 0);

    // --- out-of-range index on the 3-channel instance ---
    cfg_write(2'd0, MODE_PWM, 16'd1, 8'd255);
    cfg_write(2'd1, MODE_PWM, 16'd1, 8'd0);
    cfg_write(2'd2, MODE_OFF, 16'd1, 8'd0);
    cfg_write(2'd3, MODE_PWM, 16'd1, 8'd255);
    repeat (2) @(negedge CLK);
    err_a = 0; err_b = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (led != 4'b1001) err_a++;
      if (led3 != 3'b001) err_b++;
    end
    chk("idx3_four_ch_errors", err_a, 0);
    chk("idx3_ignored_errors", err_b, 0);

    // --- reset mid-operation ---
    cfg_write(2'd0, MODE_BLINK, 16'd1, 8'd0);
    cfg_write(2'd1, MODE_PWM, 16'd1, 8'd255);
    repeat (15) @(negedge CLK);
    chk("pre_reset_pwm_on", int'(led[1]), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midreset_led", int'(led), 0);
    chk("midreset_led3", int'(led3), 0);
    chk("midreset_tick", int'(tick), 0);
    err_a = 0; err_b = 0; err_c = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (led != 4'b0000) err_a++;
      if (led3 != 3'b000) err_c++;
      if (tick != ((n % 10) == 9)) err_b++;
    end
    chk("after_reset_led_errors", err_a, 0);
    chk("after_reset_led3_errors", err_c, 0);
    chk("after_reset_tick_errors", err_b, 0);
    cfg_write(2'd0, MODE_PWM, 16'd1, 8'd255);
    @(negedge CLK);
    chk("rewrite_after_reset", int'(led), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
